std_outlier_detector: RTL and testbench

Scores each ADC sample against its section's selected mean and standard deviation and flags outliers whose absolute deviation exceeds K·stdev. Sits directly downstream of the per-section mean/stdev selection muxes, which are combinational and driven by the same `adc_section` as this block. Adds a 3-stage scoring pipeline, per-section saturating outlier counters and a consecutive-outlier alarm FSM.

---
 rtl/std_outlier_detector_pkg.sv | 17 +
 rtl/section_outlier_counter.sv | 37 +++
 rtl/std_outlier_detector.sv | 196 +++++++++++++++++++
 tb/tb_std_outlier_detector.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_outlier_detector_pkg.sv
// Shared types and widths for the outlier detector: fixed-point format,
// section index, alarm FSM states and datapath widths.
package std_outlier_detector_pkg;

    localparam int FRAC_BITS = 16;
    localparam int DEV_W     = 33;
    localparam int THR_W     = 36;

    typedef logic [1:0] section_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        ALARM
    } state_t;

endpackage

// File: rtl/section_outlier_counter.sv
// Single saturating event counter with synchronous clear; clear wins over
// an increment in the same cycle.
module section_outlier_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: the default assignment comes first so every path assigns cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/std_outlier_detector.sv
// Scores ADC samples against the selected mean/stdev, flags |dev| > K*stdev,
// counts outliers per section and raises an alarm on N consecutive ones.
module std_outlier_detector
    import std_outlier_detector_pkg::*;
#(
    parameter int K_MULT   = 3,
    parameter int N_CONSEC = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [15:0]          adc_sample,
    input  logic [1:0]           adc_section,
    input  logic [31:0]          mean_i,
    input  logic [31:0]          std_i,
    input  logic                 alarm_clr,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic                 outlier_o,
    output logic [1:0]           section_o,
    output logic [DEV_W-1:0]     dev_abs_o,
    output logic                 alarm_o,
    output logic [1:0]           alarm_section_o,
    output logic [4*CNT_W-1:0]   outlier_cnt_o
);

    localparam logic [7:0] N_CONSEC_L = 8'(N_CONSEC);

    // Register ranks: input capture, dev/thr, abs/compare, output.
    logic                    in_v_q,    in_v_d;
    logic [15:0]             in_smp_q,  in_smp_d;
    section_t                in_sec_q,  in_sec_d;
    logic [31:0]             in_mean_q, in_mean_d;
    logic [31:0]             in_std_q,  in_std_d;

    logic                    s1_v_q,   s1_v_d;
    section_t                s1_sec_q, s1_sec_d;
    logic signed [DEV_W-1:0] s1_dev_q, s1_dev_d;
    logic [THR_W-1:0]        s1_thr_q, s1_thr_d;

    logic                    s2_v_q,   s2_v_d;
    section_t                s2_sec_q, s2_sec_d;
    logic [DEV_W-1:0]        s2_abs_q, s2_abs_d;
    logic                    s2_out_q, s2_out_d;

    logic                    out_valid_q, out_valid_d;
    logic                    outlier_q,   outlier_d;
    section_t                section_q,   section_d;
    logic [DEV_W-1:0]        dev_abs_q,   dev_abs_d;

    logic signed [DEV_W-1:0] sample_ext;
    logic signed [DEV_W-1:0] mean_ext;
    logic [DEV_W-1:0]        abs_w;

    always_comb begin
        in_v_d    = in_valid;
        in_smp_d  = adc_sample;
        in_sec_d  = section_t'(adc_section);
        in_mean_d = mean_i;
        in_std_d  = std_i;

        // Both operands fit in 33 signed bits, so the difference cannot wrap.
        sample_ext = {in_smp_q[15], in_smp_q, {FRAC_BITS{1'b0}}};
        mean_ext   = {in_mean_q[31], in_mean_q};
        s1_v_d     = in_v_q;
        s1_sec_d   = in_sec_q;
        s1_dev_d   = sample_ext - mean_ext;
        s1_thr_d   = THR_W'(in_std_q) * THR_W'(K_MULT);

        abs_w    = s1_dev_q[DEV_W-1] ? $unsigned(-s1_dev_q) : $unsigned(s1_dev_q);
        s2_v_d   = s1_v_q;
        s2_sec_d = s1_sec_q;
        s2_abs_d = abs_w;
        s2_out_d = {{(THR_W-DEV_W){1'b0}}, abs_w} > s1_thr_q;

        out_valid_d = s2_v_q;
        outlier_d   = s2_out_q;
        section_d   = s2_sec_q;
        dev_abs_d   = s2_abs_q;
    end

    // NOTE: datapath registers are reset as well, so every output reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v_q      <= 1'b0;
            in_smp_q    <= '0;
            in_sec_q    <= '0;
            in_mean_q   <= '0;
            in_std_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_sec_q    <= '0;
            s1_dev_q    <= '0;
            s1_thr_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_sec_q    <= '0;
            s2_abs_q    <= '0;
            s2_out_q    <= 1'b0;
            out_valid_q <= 1'b0;
            outlier_q   <= 1'b0;
            section_q   <= '0;
            dev_abs_q   <= '0;
        end else begin
            in_v_q      <= in_v_d;
            in_smp_q    <= in_smp_d;
            in_sec_q    <= in_sec_d;
            in_mean_q   <= in_mean_d;
            in_std_q    <= in_std_d;
            s1_v_q      <= s1_v_d;
            s1_sec_q    <= s1_sec_d;
            s1_dev_q    <= s1_dev_d;
            s1_thr_q    <= s1_thr_d;
            s2_v_q      <= s2_v_d;
            s2_sec_q    <= s2_sec_d;
            s2_abs_q    <= s2_abs_d;
            s2_out_q    <= s2_out_d;
            out_valid_q <= out_valid_d;
            outlier_q   <= outlier_d;
            section_q   <= section_d;
            dev_abs_q   <= dev_abs_d;
        end
    end

    assign out_valid = out_valid_q;
    assign outlier_o = outlier_q;
    assign section_o = section_q;
    assign dev_abs_o = dev_abs_q;

    state_t   state_q,   state_d;
    logic [7:0] run_q,   run_d;
    section_t run_sec_q, run_sec_d;

    // alarm_clr wins over a scored result; that result still reaches the counters.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        run_sec_d = run_sec_q;
        if (alarm_clr) begin
            state_d = IDLE;
            run_d   = '0;
        end else if (out_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (outlier_q) begin
                        run_d     = 8'd1;
                        run_sec_d = section_q;
                        state_d   = (N_CONSEC == 1) ? ALARM : COUNT;
                    end
                end
                COUNT: begin
                    if (!outlier_q) begin
                        run_d   = '0;
                        state_d = IDLE;
                    end else if (section_q == run_sec_q) begin
                        run_d = run_q + 8'd1;
                        if (run_q + 8'd1 == N_CONSEC_L) begin
                            state_d = ALARM;
                        end
                    end else begin
                        run_d     = 8'd1;
                        run_sec_d = section_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_q     <= '0;
            run_sec_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            run_sec_q <= run_sec_d;
        end
    end

    assign alarm_o         = (state_q == ALARM);
    assign alarm_section_o = alarm_o ? run_sec_q : 2'b00;

    for (genvar s = 0; s < 4; s++) begin : g_cnt
        section_outlier_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (cnt_clr),
            .inc   (out_valid_q && outlier_q && (section_q == section_t'(s))),
            .cnt_o (outlier_cnt_o[s*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_std_outlier_detector.sv
// Directed bench for std_outlier_detector: scored results are checked against
// a scoreboard filled by an arithmetic model at drive time.
module tb_std_outlier_detector;

    localparam int K  = 3;
    localparam int NC = 4;
    localparam int CW = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] adc_sample = '0;
    logic [1:0]         adc_section = '0;
    logic [31:0]        mean_i = '0;
    logic [31:0]        std_i = '0;
    logic               alarm_clr = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               out_valid;
    logic               outlier_o;
    logic [1:0]         section_o;
    logic [32:0]        dev_abs_o;
    logic               alarm_o;
    logic [1:0]         alarm_section_o;
    logic [4*CW-1:0]    outlier_cnt_o;

    std_outlier_detector #(
        .K_MULT   (K),
        .N_CONSEC (NC),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .adc_sample      (adc_sample),
        .adc_section     (adc_section),
        .mean_i          (mean_i),
        .std_i           (std_i),
        .alarm_clr       (alarm_clr),
        .cnt_clr         (cnt_clr),
        .out_valid       (out_valid),
        .outlier_o       (outlier_o),
        .section_o       (section_o),
        .dev_abs_o       (dev_abs_o),
        .alarm_o         (alarm_o),
        .alarm_section_o (alarm_section_o),
        .outlier_cnt_o   (outlier_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sec;
        logic        outl;
        logic [32:0] dev;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int s);
        return outlier_cnt_o[s*CW +: CW];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one sample for one cycle and queue its expected score.
    task automatic send(input logic signed [15:0] s, input logic [1:0] sec);
        longint d, a, t;
        exp_t   e;
        adc_sample  = s;
        adc_section = sec;
        in_valid    = 1'b1;
        d = longint'(s) * 65536 - longint'($signed(mean_i));
        a = (d < 0) ? -d : d;
        t = longint'(std_i) * K;
        e.sec  = sec;
        e.outl = (a > t);
        e.dev  = 33'(a);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_alarm_clr();
        alarm_clr = 1'b1;
        step(1);
        alarm_clr = 1'b0;
    endtask

    task automatic pulse_cnt_clr();
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("section_o", 64'(section_o), 64'(mon_e.sec));
                check("outlier_o", 64'(outlier_o), 64'(mon_e.outl));
                check("dev_abs_o", 64'(dev_abs_o), 64'(mon_e.dev));
            end
        end
    end

    initial begin
        mean_i = 32'h0064_0000;
        std_i  = 32'h000A_0000;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outlier", 64'(outlier_o), 64'd0);
        check("rst_section", 64'(section_o), 64'd0);
        check("rst_dev_abs", 64'(dev_abs_o), 64'd0);
        check("rst_alarm", 64'(alarm_o), 64'd0);
        check("rst_alarm_sec", 64'(alarm_section_o), 64'd0);
        check("rst_cnt", 64'(outlier_cnt_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Threshold edge and latency, section 0.
        send(16'sd131, 2'd0);
        step(2);
        check("latency_early", 64'(out_valid), 64'd0);
        step(1);
        check("latency_due", 64'(out_valid), 64'd1);
        send(16'sd130, 2'd0);
        send(16'sd69, 2'd0);
        step(6);
        check("cnt0_threshold", 64'(cnt(0)), 64'd2);
        check("no_alarm_threshold", 64'(alarm_o), 64'd0);
        pulse_alarm_clr();
        pulse_cnt_clr();

        // Four back-to-back outliers in section 2.
        repeat (4) send(16'sd131, 2'd2);
        step(3);
        check("alarm_before_rise", 64'(alarm_o), 64'd0);
        step(1);
        check("alarm_rise", 64'(alarm_o), 64'd1);
        check("alarm_sec2", 64'(alarm_section_o), 64'd2);
        check("cnt2_alarm", 64'(cnt(2)), 64'd4);
        pulse_alarm_clr();
        check("alarm_cleared", 64'(alarm_o), 64'd0);
        check("alarm_sec_cleared", 64'(alarm_section_o), 64'd0);

        // Bubbles between section-1 outliers do not break the run.
        send(16'sd131, 2'd1);
        step(2);
        send(16'sd131, 2'd1);
        step(3);
        send(16'sd131, 2'd1);
        step(1);
        send(16'sd131, 2'd1);
        step(6);
        check("alarm_bubbles", 64'(alarm_o), 64'd1);
        check("alarm_sec1", 64'(alarm_section_o), 64'd1);
        pulse_alarm_clr();

        // A non-outlier resets the run.
        send(16'sd131, 2'd1);
        send(16'sd131, 2'd1);
        send(16'sd100, 2'd1);
        send(16'sd131, 2'd1);
        step(6);
        check("break_no_alarm", 64'(alarm_o), 64'd0);
        repeat (2) send(16'sd131, 2'd1);
        step(6);
        check("break_run3", 64'(alarm_o), 64'd0);
        send(16'sd131, 2'd1);
        step(6);
        check("break_run4", 64'(alarm_o), 64'd1);
        pulse_alarm_clr();

        // A section switch restarts the run at 1.
        repeat (3) send(16'sd131, 2'd1);
        repeat (3) send(16'sd69, 2'd0);
        step(6);
        check("switch_run3", 64'(alarm_o), 64'd0);
        send(16'sd131, 2'd0);
        step(6);
        check("switch_alarm", 64'(alarm_o), 64'd1);
        check("switch_alarm_sec", 64'(alarm_section_o), 64'd0);
        pulse_alarm_clr();

        // Saturation of a 4-bit counter and clear-over-increment.
        pulse_cnt_clr();
        repeat (20) send(16'sd131, 2'd3);
        step(6);
        check("cnt3_saturated", 64'(cnt(3)), 64'd15);
        check("cnt1_untouched", 64'(cnt(1)), 64'd0);
        send(16'sd131, 2'd3);
        step(3);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("cnt3_clr_priority", 64'(cnt(3)), 64'd0);
        send(16'sd131, 2'd3);
        step(6);
        check("cnt3_after_clr", 64'(cnt(3)), 64'd1);
        pulse_alarm_clr();

        // Zero stdev and extreme deviation.
        std_i = 32'h0;
        send(16'sd100, 2'd0);
        send(16'sd101, 2'd0);
        std_i  = 32'h000A_0000;
        mean_i = 32'h7FFF_FFFF;
        send(-16'sd32768, 2'd2);
        mean_i = 32'h0064_0000;
        step(6);
        pulse_alarm_clr();
        pulse_cnt_clr();

        // Asynchronous reset during the third outlier of a run.
        repeat (2) send(16'sd131, 2'd1);
        step(6);
        send(16'sd131, 2'd1);
        step(3);
        check("mid_out_valid_before", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outlier", 64'(outlier_o), 64'd0);
        check("mid_rst_section", 64'(section_o), 64'd0);
        check("mid_rst_dev_abs", 64'(dev_abs_o), 64'd0);
        check("mid_rst_alarm", 64'(alarm_o), 64'd0);
        check("mid_rst_cnt", 64'(outlier_cnt_o), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        repeat (3) send(16'sd131, 2'd1);
        step(6);
        check("run_restart_3", 64'(alarm_o), 64'd0);
        send(16'sd131, 2'd1);
        step(6);
        check("run_restart_4", 64'(alarm_o), 64'd1);
        check("run_restart_sec", 64'(alarm_section_o), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
